// File: rtl/ulpi_pkg.sv
// Shared ULPI definitions: RX CMD event codes, TX CMD prefix,
// Function Control bit positions and the init FSM state type.
package ulpi_pkg;

    // RxEvent field, RX CMD bits [5:4]
    typedef enum logic [1:0] {
        RXEV_NONE    = 2'b00,
        RXEV_ACTIVE  = 2'b01,
        RXEV_HOSTDIS = 2'b10,
        RXEV_ERROR   = 2'b11
    } rx_event_e;

    // TX CMD prefix for an immediate register write
    localparam logic [1:0] TXCMD_REGW = 2'b10;

    // Function Control register bit positions
    localparam int FC_XCVR_LSB   = 0;
    localparam int FC_TERMSEL    = 2;
    localparam int FC_OPMODE_LSB = 3;
    localparam int FC_RESET      = 5;
    localparam int FC_SUSPENDM   = 6;

    typedef enum logic [2:0] {
        ST_IDLE_WAIT,
        ST_CMD,
        ST_DATA,
        ST_STP,
        ST_DONE
    } init_state_e;

    function automatic logic [7:0] regw_cmd(input logic [5:0] addr);
        return {TXCMD_REGW, addr};
    endfunction

endpackage

// File: rtl/ulpi_rx_framer.sv
// One-byte holder that turns accepted ULPI bytes into a framed stream.
// Ports: byte_vld_i/byte_i accepted byte, err_set_i RxError event,
//        rx_fall_i RxActive falling, pkt_* framed output (registered).
module ulpi_rx_framer (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       byte_vld_i,
    input  logic [7:0] byte_i,
    input  logic       err_set_i,
    input  logic       rx_fall_i,
    output logic       pkt_valid_o,
    output logic [7:0] pkt_data_o,
    output logic       pkt_last_o,
    output logic       pkt_error_o
);

    logic       full_q, full_d;
    logic [7:0] hold_q, hold_d;
    logic       err_q, err_d;
    logic       valid_q, valid_d;
    logic [7:0] data_q, data_d;
    logic       last_q, last_d;
    logic       perr_q, perr_d;

    always_comb begin
        full_d  = full_q;
        hold_d  = hold_q;
        err_d   = err_q;
        valid_d = 1'b0;
        data_d  = 8'h00;
        last_d  = 1'b0;
        perr_d  = 1'b0;

        if (err_set_i) begin
            err_d = 1'b1;
        end

        // A byte is only known to be non-final once its successor arrives
        if (byte_vld_i) begin
            if (full_q) begin
                valid_d = 1'b1;
                data_d  = hold_q;
            end
            hold_d = byte_i;
            full_d = 1'b1;
        end else if (rx_fall_i) begin
            if (full_q) begin
                valid_d = 1'b1;
                data_d  = hold_q;
                last_d  = 1'b1;
                perr_d  = err_q;
            end
            full_d = 1'b0;
            err_d  = 1'b0;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            full_q  <= 1'b0;
            hold_q  <= 8'h00;
            err_q   <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= 8'h00;
            last_q  <= 1'b0;
            perr_q  <= 1'b0;
        end else begin
            full_q  <= full_d;
            hold_q  <= hold_d;
            err_q   <= err_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            last_q  <= last_d;
            perr_q  <= perr_d;
        end
    end

    assign pkt_valid_o = valid_q;
    assign pkt_data_o  = data_q;
    assign pkt_last_o  = last_q;
    assign pkt_error_o = perr_q;

endmodule

// File: rtl/ulpi_sniff_rx.sv
// Link-side ULPI front end: one Function Control write at init, then
// RX CMD / data decode into a framed byte stream and line state.
// Ports: ulpi_* pad bus, init_done_o, linestate_o, rx_active_o, pkt_*.
module ulpi_sniff_rx
    import ulpi_pkg::*;
#(
    parameter logic [5:0] FUNC_CTRL_ADDR = 6'h04,
    parameter logic [7:0] FUNC_CTRL_VAL  = 8'h48
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic [7:0] ulpi_data_i,
    output logic [7:0] ulpi_data_o,
    input  logic       ulpi_dir_i,
    input  logic       ulpi_nxt_i,
    output logic       ulpi_stp_o,
    output logic       init_done_o,
    output logic [1:0] linestate_o,
    output logic       rx_active_o,
    output logic       pkt_valid_o,
    output logic [7:0] pkt_data_o,
    output logic       pkt_last_o,
    output logic       pkt_error_o
);

    init_state_e state_q, state_d;
    logic [7:0]  txd_q, txd_d;
    logic        stp_q, stp_d;
    logic        done_q, done_d;
    logic        dir_q, dir_d;
    logic        rx_active_q, rx_active_d;
    logic [1:0]  ls_q, ls_d;

    logic        turn;
    logic        rx_cmd;
    logic        rx_byte;
    logic        err_set;
    logic        byte_vld;
    logic        rx_fall;
    rx_event_e   ev;

    // Receive decode
    always_comb begin
        turn        = ulpi_dir_i & ~dir_q;
        rx_cmd      = ulpi_dir_i & dir_q & ~ulpi_nxt_i;
        rx_byte     = ulpi_dir_i & dir_q & ulpi_nxt_i;
        ev          = rx_event_e'(ulpi_data_i[5:4]);
        dir_d       = ulpi_dir_i;
        rx_active_d = rx_active_q;
        ls_d        = ls_q;
        err_set     = 1'b0;

        if (!ulpi_dir_i) begin
            rx_active_d = 1'b0;
        end else if (turn) begin
            // dir and nxt together signal RxActive at turnaround
            rx_active_d = ulpi_nxt_i;
        end else if (rx_cmd) begin
            ls_d = ulpi_data_i[1:0];
            unique case (ev)
                RXEV_ACTIVE: rx_active_d = 1'b1;
                RXEV_ERROR: begin
                    rx_active_d = 1'b1;
                    err_set     = 1'b1;
                end
                default: rx_active_d = 1'b0;
            endcase
        end

        byte_vld = rx_byte & rx_active_q;
        rx_fall  = rx_active_q & ~rx_active_d;
    end

    // Init FSM; outputs are registered from the next state
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE_WAIT: begin
                if (!dir_q && !ulpi_dir_i) state_d = ST_CMD;
            end
            ST_CMD: begin
                if (ulpi_dir_i)      state_d = ST_IDLE_WAIT;
                else if (ulpi_nxt_i) state_d = ST_DATA;
            end
            ST_DATA: begin
                if (ulpi_dir_i)      state_d = ST_IDLE_WAIT;
                else if (ulpi_nxt_i) state_d = ST_STP;
            end
            ST_STP:  state_d = ST_DONE;
            default: state_d = ST_DONE;
        endcase

        txd_d  = 8'h00;
        stp_d  = 1'b0;
        done_d = 1'b0;
        unique case (state_d)
            ST_CMD:  txd_d  = regw_cmd(FUNC_CTRL_ADDR);
            ST_DATA: txd_d  = FUNC_CTRL_VAL;
            ST_STP:  stp_d  = 1'b1;
            ST_DONE: done_d = 1'b1;
            default: txd_d  = 8'h00;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q     <= ST_IDLE_WAIT;
            txd_q       <= 8'h00;
            stp_q       <= 1'b0;
            done_q      <= 1'b0;
            dir_q       <= 1'b0;
            rx_active_q <= 1'b0;
            ls_q        <= 2'b00;
        end else begin
            state_q     <= state_d;
            txd_q       <= txd_d;
            stp_q       <= stp_d;
            done_q      <= done_d;
            dir_q       <= dir_d;
            rx_active_q <= rx_active_d;
            ls_q        <= ls_d;
        end
    end

    ulpi_rx_framer u_framer (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .byte_vld_i (byte_vld),
        .byte_i     (ulpi_data_i),
        .err_set_i  (err_set),
        .rx_fall_i  (rx_fall),
        .pkt_valid_o(pkt_valid_o),
        .pkt_data_o (pkt_data_o),
        .pkt_last_o (pkt_last_o),
        .pkt_error_o(pkt_error_o)
    );

    assign ulpi_data_o = txd_q;
    assign ulpi_stp_o  = stp_q;
    assign init_done_o = done_q;
    assign linestate_o = ls_q;
    assign rx_active_o = rx_active_q;

endmodule
